// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the helper function that sizes the burst counter.
package uart_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    GRANT   = ST_GRANT,
    RELEASE = ST_RELEASE
  } arb_state_t;

  // Enough bits to count 0..max_burst inclusive.
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin selector: first asserted request after 'last', with wrap.
// Optional build macro UART_TX_ARB_PRIO0_EN gives requester 0 absolute priority.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  logic prio0;

`ifdef UART_TX_ARB_PRIO0_EN
  assign prio0 = req[0];
`else
  assign prio0 = 1'b0;
`endif

  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    if (prio0) begin
      grant[0] = 1'b1;
      valid    = 1'b1;
    end else begin
      // Scan last+1 .. last+NUM_REQ so the previous winner is checked last.
      for (int i = 1; i <= NUM_REQ; i++) begin
        k = (int'(last) + i) % NUM_REQ;
        if (!valid && req[k]) begin
          grant[k] = 1'b1;
          idx      = IW'(k);
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter multiplexing several byte FIFOs onto one UART transmitter,
// with a per-turn burst limit. Optional build macro: UART_TX_ARB_PRIO0_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_UART = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic [NUM_REQ-1:0]             req_load_i,
  input  logic [NUM_REQ*DATA_UART-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]             req_pull_o,
  output logic                           tx_load_o,
  output logic [DATA_UART-1:0]           tx_data_o,
  input  logic                           tx_pull_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic                           busy_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = burst_cnt_w(MAX_BURST);

  arb_state_t         state;
  logic [IW-1:0]      gidx;
  logic [IW-1:0]      last_grant;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q;
  logic [CW-1:0]      burst_cnt;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               in_grant;
  logic               g_load;
  logic               at_limit;
  logic               release_now;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req   (req_load_i),
    .last  (last_grant),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign in_grant = (state == GRANT);
  assign g_load   = req_load_i[gidx];
  assign at_limit = (burst_cnt + 1'b1) == CW'(MAX_BURST);

  // A pull always completes its byte; only a pull-free cycle may end the turn early.
  assign release_now = (tx_pull_i && at_limit) ||
                       (!tx_pull_i && (!g_load || !en_i));

  assign tx_load_o = in_grant & g_load;
  assign tx_data_o = in_grant ? req_data_i[gidx*DATA_UART +: DATA_UART] : '0;
  assign grant_o   = grant_q;
  assign busy_o    = busy_q;

  always_comb begin
    req_pull_o = '0;
    if (in_grant) req_pull_o[gidx] = tx_pull_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant_q    <= '0;
      gidx       <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      burst_cnt  <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en_i && pick_valid) begin
            state     <= GRANT;
            grant_q   <= pick_grant;
            gidx      <= pick_idx;
            burst_cnt <= '0;
            busy_q    <= 1'b1;
          end
        end
        GRANT: begin
          if (tx_pull_i) burst_cnt <= burst_cnt + 1'b1;
          if (release_now) begin
            state   <= RELEASE;
            grant_q <= '0;
          end
        end
        RELEASE: begin
          last_grant <= gidx;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table plus hand-written multi-cycle sequences.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  load;
  logic [31:0] data;
  logic        pull;

  logic [3:0]  req_pull_a, grant_a;
  logic        tx_load_a, busy_a;
  logic [7:0]  tx_data_a;
  logic [3:0]  req_pull_b, grant_b;
  logic        tx_load_b, busy_b;
  logic [7:0]  tx_data_b;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_UART(8), .MAX_BURST(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_load_i(load), .req_data_i(data),
    .req_pull_o(req_pull_a), .tx_load_o(tx_load_a), .tx_data_o(tx_data_a),
    .tx_pull_i(pull), .grant_o(grant_a), .busy_o(busy_a)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_UART(8), .MAX_BURST(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_load_i(load), .req_data_i(data),
    .req_pull_o(req_pull_b), .tx_load_o(tx_load_b), .tx_data_o(tx_data_b),
    .tx_pull_i(pull), .grant_o(grant_b), .busy_o(busy_b)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] load;
    logic       pull;
    logic [3:0] grant;
    logic       busy;
    logic       txl;
    logic [7:0] txd;
    logic [3:0] rpull;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; load = 4'h0; pull = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_rr[5];
    int f0, f1, ne, t;
    logic [3:0] prev, eg[4];
    int ecnt[4];

    // Table rows: inputs for a cycle, then the outputs expected during that cycle (MAX_BURST=4 instance).
    vt[0]  = '{1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vt[1]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vt[2]  = '{1'b0, 1'b0, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vt[3]  = '{1'b0, 1'b1, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vt[4]  = '{1'b0, 1'b1, 4'h2, 1'b0, 4'h2, 1'b1, 1'b1, 8'hA1, 4'h0};
    vt[5]  = '{1'b0, 1'b1, 4'h2, 1'b1, 4'h2, 1'b1, 1'b1, 8'hA1, 4'h2};
    vt[6]  = '{1'b0, 1'b1, 4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 8'hA1, 4'h0};
    vt[7]  = '{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0};
    vt[8]  = '{1'b0, 1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vt[9]  = '{1'b0, 1'b1, 4'h8, 1'b0, 4'h8, 1'b1, 1'b1, 8'hA3, 4'h0};
    vt[10] = '{1'b0, 1'b0, 4'h8, 1'b0, 4'h8, 1'b1, 1'b1, 8'hA3, 4'h0};
    vt[11] = '{1'b0, 1'b1, 4'h8, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0};
    vt[12] = '{1'b0, 1'b1, 4'h9, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vt[13] = '{1'b0, 1'b1, 4'hB, 1'b1, 4'h1, 1'b1, 1'b1, 8'hA0, 4'h1};
    vt[14] = '{1'b0, 1'b0, 4'hB, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA0, 4'h0};
    vt[15] = '{1'b0, 1'b1, 4'hB, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0};
    vt[16] = '{1'b0, 1'b1, 4'hB, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
`ifdef UART_TX_ARB_PRIO0_EN
    vt[17] = '{1'b0, 1'b1, 4'hB, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA0, 4'h0};
`else
    vt[17] = '{1'b0, 1'b1, 4'hB, 1'b0, 4'h2, 1'b1, 1'b1, 8'hA1, 4'h0};
`endif

    data = 32'hA3A2A1A0;
    rst = 1'b1; en = 1'b0; load = 4'h0; pull = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst = vt[i].rst; en = vt[i].en; load = vt[i].load; pull = vt[i].pull;
      #1;
      chk($sformatf("tbl%0d_grant", i), 32'(grant_b), 32'(vt[i].grant));
      chk($sformatf("tbl%0d_busy", i), 32'(busy_b), 32'(vt[i].busy));
      chk($sformatf("tbl%0d_txload", i), 32'(tx_load_b), 32'(vt[i].txl));
      chk($sformatf("tbl%0d_txdata", i), 32'(tx_data_b), 32'(vt[i].txd));
      chk($sformatf("tbl%0d_reqpull", i), 32'(req_pull_b), 32'(vt[i].rpull));
    end

    // Reset in the middle of a burst held by requester 2.
    do_reset();
    en = 1'b1; load = 4'b0100;
    @(negedge clk); #1;
    chk("midrst_grant_pre", 32'(grant_b), 32'h4);
    pull = 1'b1; #1;
    chk("midrst_pull_pre", 32'(req_pull_b), 32'h4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0; pull = 1'b0; #1;
    chk("midrst_grant", 32'(grant_b), 32'h0);
    chk("midrst_busy", 32'(busy_b), 32'h0);
    chk("midrst_txload", 32'(tx_load_b), 32'h0);

    // Round-robin rotation with one byte per turn (MAX_BURST=1 instance).
    exp_rr = '{0, 1, 2, 3, 0};
    do_reset();
    en = 1'b1; load = 4'hF; #1;
    for (int n = 0; n < 5; n++) begin
      t = 0;
      while (grant_a == 4'h0 && t < 8) begin
        @(negedge clk); #1; t++;
      end
      chk($sformatf("rr%0d_grant", n), 32'(grant_a), 32'(1) << exp_rr[n]);
      chk($sformatf("rr%0d_data", n), 32'(tx_data_a), 32'hA0 + 32'(exp_rr[n]));
      chk($sformatf("rr%0d_ld_busy", n), 32'({tx_load_a, busy_a}), 32'h3);
      pull = 1'b1; #1;
      chk($sformatf("rr%0d_pull", n), 32'(req_pull_a), 32'(1) << exp_rr[n]);
      @(negedge clk);
      pull = 1'b0; #1;
    end

    // Burst limit on requester 0 (6 bytes) and early release of requester 1 (2 bytes).
    do_reset();
    f0 = 6; f1 = 2; ne = 0; prev = 4'h0; t = 0;
    for (int k = 0; k < 4; k++) begin eg[k] = 4'h0; ecnt[k] = 0; end
    en = 1'b1;
    while (t < 80 && !(ne >= 3 && busy_b == 1'b0)) begin
      @(negedge clk);
      load = {2'b00, f1 > 0, f0 > 0}; #1;
      pull = tx_load_b; #1;
      if (grant_b != 4'h0 && prev == 4'h0 && ne < 4) begin
        eg[ne] = grant_b; ne++;
      end
      if (ne > 0 && req_pull_b[0]) begin f0--; ecnt[ne-1]++; end
      if (ne > 0 && req_pull_b[1]) begin f1--; ecnt[ne-1]++; end
      prev = grant_b; t++;
    end
    pull = 1'b0;
    chk("burst_turns", 32'(ne), 32'd3);
    chk("burst_t0_grant", 32'(eg[0]), 32'h1);
    chk("burst_t0_pulls", 32'(ecnt[0]), 32'd4);
    chk("burst_t1_grant", 32'(eg[1]), 32'h2);
    chk("burst_t1_pulls", 32'(ecnt[1]), 32'd2);
    chk("burst_t2_grant", 32'(eg[2]), 32'h1);
    chk("burst_t2_pulls", 32'(ecnt[2]), 32'd2);

    // Enable drops in the same cycle as a pull.
    do_reset();
    en = 1'b1; load = 4'b0001;
    @(negedge clk);
    en = 1'b0; pull = 1'b1; #1;
    chk("dis_pull_fwd", 32'(req_pull_b), 32'h1);
    @(negedge clk);
    pull = 1'b0; #1;
    t = 0;
    while (busy_b != 1'b0 && t < 4) begin
      @(negedge clk); #1; t++;
    end
    chk("dis_released", 32'(busy_b), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk($sformatf("dis_nogrant%0d", k), 32'(grant_b), 32'h0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of transmit requesters, range 2..8.
REQ-002 SHALL have parameter DATA_UART, default 8: UART data byte width.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum bytes granted per requester per turn, range 1..15.
REQ-004 SHALL have port clk_i  input  1  system clock; single clock domain, all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port en_i  input  1  arbiter enable.
REQ-007 SHALL have port req_load_i  input  NUM_REQ  per-requester data-available flag (FIFO non-empty).
REQ-008 SHALL have port req_data_i  input  NUM_REQ*DATA_UART  per-requester head byte; requester k occupies bits [k*DATA_UART +: DATA_UART].
REQ-009 SHALL have port req_pull_o  output  NUM_REQ  one-cycle pop strobe to the granted requester.
REQ-010 SHALL have port tx_load_o  output  1  data-available flag to the UART controller.
REQ-011 SHALL have port tx_data_o  output  DATA_UART  byte presented to the UART controller.
REQ-012 SHALL have port tx_pull_i  input  1  one-cycle pull strobe from the UART controller.
REQ-013 SHALL have port grant_o  output  NUM_REQ  one-hot current grant, all-zero when idle.
REQ-014 SHALL have port busy_o  output  1  high while any grant is held.

Function
REQ-015 SHALL implement states IDLE, GRANT, RELEASE.
REQ-016 IDLE: when en_i=1 and req_load_i!=0, SHALL register a grant to the first requester with req_load_i=1 scanning from (last_grant+1) mod NUM_REQ upward with wrap, and enter GRANT next cycle.
REQ-017 IDLE with en_i=0 or req_load_i=0 SHALL remain in IDLE.
REQ-018 GRANT: tx_load_o SHALL equal req_load_i[g] and tx_data_o SHALL equal requester g's byte, combinationally, where g is the granted index.
REQ-019 GRANT: req_pull_o[g] SHALL equal tx_pull_i in the same cycle; all other req_pull_o bits SHALL be 0.
REQ-020 Each tx_pull_i in GRANT SHALL increment a burst counter (width $clog2(MAX_BURST+1)), cleared on entry to GRANT.
REQ-021 GRANT SHALL go to RELEASE when: tx_pull_i=1 and counter+1=MAX_BURST; or req_load_i[g]=0 and tx_pull_i=0; or en_i=0 and tx_pull_i=0.
REQ-022 A tx_pull_i arriving in the same cycle as en_i=0 or req_load_i[g] deassertion SHALL still be forwarded to req_pull_o[g] and counted.
REQ-023 RELEASE SHALL last exactly one cycle: tx_load_o=0, req_pull_o=0, last_grant<=g, grant cleared; then IDLE.
REQ-024 Outside GRANT: tx_load_o=0, tx_data_o=0, req_pull_o=0, grant_o=0.
REQ-025 busy_o SHALL be 1 in GRANT and RELEASE, 0 in IDLE.
REQ-026 Grant latency SHALL be one cycle from request sampled in IDLE to tx_load_o=1.
REQ-027 tx_pull_i while not in GRANT SHALL be ignored.

Reset
REQ-028 rst_i=1 at a clock edge SHALL force IDLE, grant_o=0, counter=0, last_grant=NUM_REQ-1, all outputs 0; takes priority over every other event including mid-burst.

Configuration
REQ-029 Macro UART_TX_ARB_PRIO0_EN defined: requester 0 SHALL win in IDLE whenever req_load_i[0]=1, bypassing round-robin; other requesters use round-robin among themselves.
REQ-030 Macro UART_TX_ARB_PRIO0_EN undefined: pure round-robin per REQ-016.

Structure
REQ-031 State encoding localparams and the burst-counter width function SHALL reside in shared package uart_pkg.
REQ-032 SHALL contain one sub-module uart_rr_picker: combinational round-robin next-grant selector (request vector, last index -> one-hot grant, valid).

Verification
REQ-033 Reset mid-burst: rst_i=1 during GRANT with g=2 -> next cycle grant_o=0, busy_o=0, tx_load_o=0.
REQ-034 Round-robin: req_load_i=4'b1111 held, MAX_BURST=1, tx_pull_i pulsed each GRANT -> grant order 0,1,2,3,0.
REQ-035 Burst limit: req_load_i=4'b0011, MAX_BURST=4, 6 bytes in requester 0 -> 4 req_pull_o[0] pulses, RELEASE, then grant 1.
REQ-036 Early release: requester 1 empties after 2 pulls -> RELEASE after the 2nd pull, req_pull_o[1] count=2.
REQ-037 Disable with simultaneous pull: en_i falls with tx_pull_i=1 -> pull forwarded, RELEASE next cycle, no new grant while en_i=0.
REQ-038 Priority (UART_TX_ARB_PRIO0_EN): last_grant=0, req_load_i=4'b1011 -> next grant 0; without macro -> next grant 1.
